// File: rtl/laundry_pkg.sv
// Shared types and pricing helper for the laundry dispatch controller.
package laundry_pkg;

    localparam int unsigned PRICE_SINGLE_DEF = 32'd2;
    localparam int unsigned PRICE_DOUBLE_DEF = 32'd3;

    typedef enum logic {
        M_FREE = 1'b0,
        M_BUSY = 1'b1
    } mach_state_e;

    // Coin units charged for a request, widened so any price fits the compare.
    function automatic logic [15:0] price_f(input logic dbl_i,
                                            input int unsigned single_i,
                                            input int unsigned double_i);
        logic [15:0] p;
        if (dbl_i) begin
            p = 16'(double_i);
        end else begin
            p = 16'(single_i);
        end
        return p;
    endfunction

endpackage

// File: rtl/job_fifo.sv
// Small synchronous FIFO holding paid jobs; contents clear on reset.
module job_fifo
    import laundry_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       head_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push_i && (count_q != DEPTH_C);
    assign do_pop_s  = pop_i && (count_q != '0);

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;

endmodule

// File: rtl/laundry_dispatch_controller.sv
// Coin credit, job queueing and round-robin dispatch to a bank of washing machines.
module laundry_dispatch_controller
    import laundry_pkg::*;
#(
    parameter int unsigned N_MACHINES   = 4,
    parameter int unsigned PRICE_SINGLE = PRICE_SINGLE_DEF,
    parameter int unsigned PRICE_DOUBLE = PRICE_DOUBLE_DEF,
    parameter int unsigned QDEPTH       = 4,
    parameter int unsigned CREDIT_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      coin,
    input  logic                      req_start,
    input  logic                      req_double,
    input  logic [N_MACHINES-1:0]     mach_en,
    input  logic [N_MACHINES-1:0]     wash_done,
    output logic [N_MACHINES-1:0]     start,
    output logic [N_MACHINES-1:0]     dbl,
    output logic [N_MACHINES-1:0]     busy,
    output logic [CREDIT_W-1:0]       credit,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      req_accept,
    output logic                      req_reject,
    output logic                      err_spurious
);

    localparam int unsigned IDX_W      = $clog2(N_MACHINES);
    localparam logic [15:0] CREDIT_MAX = 16'((32'd1 << CREDIT_W) - 32'd1);

    logic [CREDIT_W-1:0]    credit_q, credit_d;
    logic [15:0]            price_s;
    logic [15:0]            credit_sum_s;
    logic                   accept_s, reject_s;
    logic                   accept_q, reject_q;
    logic [0:0]             fifo_head_s;
    logic                   fifo_empty_s, fifo_full_s;
    logic [$clog2(QDEPTH):0] q_count_s;
    mach_state_e            state_q [N_MACHINES];
    mach_state_e            state_d [N_MACHINES];
    logic [N_MACHINES-1:0]  busy_s, eligible_s;
    logic [N_MACHINES-1:0]  start_q, start_d, dbl_q, dbl_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       cand_s, grant_idx_s;
    logic                   grant_found_s, dispatch_s;
    logic                   err_q, err_d;

    job_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (1)
    ) u_job_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (accept_s),
        .data_i  (req_double),
        .pop_i   (dispatch_s),
        .head_o  (fifo_head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s),
        .count_o (q_count_s)
    );

    // Price check and full check both look at registered state only.
    assign price_s      = price_f(req_double, PRICE_SINGLE, PRICE_DOUBLE);
    assign accept_s     = req_start && (16'(credit_q) >= price_s) && !fifo_full_s;
    assign reject_s     = req_start && !accept_s;
    assign credit_sum_s = 16'(credit_q) + 16'(coin) - (accept_s ? price_s : 16'd0);
    assign credit_d     = (credit_sum_s > CREDIT_MAX) ? CREDIT_MAX[CREDIT_W-1:0]
                                                      : credit_sum_s[CREDIT_W-1:0];

    // Machine availability from registered FSM state.
    always_comb begin
        busy_s     = '0;
        eligible_s = '0;
        for (int i = 0; i < int'(N_MACHINES); i++) begin
            busy_s[i]     = (state_q[i] == M_BUSY);
            eligible_s[i] = mach_en[i] && (state_q[i] == M_FREE);
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo N_MACHINES.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        cand_s        = '0;
        for (int k = 0; k < int'(N_MACHINES); k++) begin
            cand_s = IDX_W'((int'(rr_ptr_q) + k) % int'(N_MACHINES));
            if (!grant_found_s && eligible_s[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign dispatch_s = !fifo_empty_s && grant_found_s;
    assign rr_ptr_d   = dispatch_s ? IDX_W'((int'(grant_idx_s) + 1) % int'(N_MACHINES)) : rr_ptr_q;
    assign err_d      = err_q | (|(wash_done & ~busy_s));

    // Per-machine FREE/BUSY transitions plus start pulse and wash-mode latch.
    always_comb begin
        state_d = state_q;
        start_d = '0;
        dbl_d   = dbl_q;
        for (int i = 0; i < int'(N_MACHINES); i++) begin
            case (state_q[i])
                M_FREE: begin
                    if (dispatch_s && (grant_idx_s == IDX_W'(i))) begin
                        state_d[i] = M_BUSY;
                        start_d[i] = 1'b1;
                        dbl_d[i]   = fifo_head_s[0];
                    end else begin
                        state_d[i] = M_FREE;
                    end
                end
                M_BUSY: begin
                    if (wash_done[i]) begin
                        state_d[i] = M_FREE;
                    end else begin
                        state_d[i] = M_BUSY;
                    end
                end
                default: state_d[i] = M_FREE;
            endcase
        end
    end

    // All controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
            accept_q <= 1'b0;
            reject_q <= 1'b0;
            start_q  <= '0;
            dbl_q    <= '0;
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < int'(N_MACHINES); i++) begin
                state_q[i] <= M_FREE;
            end
        end else begin
            credit_q <= credit_d;
            accept_q <= accept_s;
            reject_q <= reject_s;
            start_q  <= start_d;
            dbl_q    <= dbl_d;
            rr_ptr_q <= rr_ptr_d;
            err_q    <= err_d;
            for (int i = 0; i < int'(N_MACHINES); i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    assign start        = start_q;
    assign dbl          = dbl_q;
    assign busy         = busy_s;
    assign credit       = credit_q;
    assign q_count      = q_count_s;
    assign req_accept   = accept_q;
    assign req_reject   = reject_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_laundry_dispatch_controller.sv
// Directed scenarios plus randomized traffic checked against a queue-based reference model.
module tb_laundry_dispatch_controller;

    localparam int N    = 4;
    localparam int PS   = 2;
    localparam int PD   = 3;
    localparam int QD   = 4;
    localparam int CMAX = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin = 1'b0;
    logic       req_start = 1'b0;
    logic       req_double = 1'b0;
    logic [3:0] mach_en = 4'hF;
    logic [3:0] wash_done = 4'h0;
    logic [3:0] start, dbl, busy, credit;
    logic [2:0] q_count;
    logic       req_accept, req_reject, err_spurious;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    int         m_credit;
    int         m_rr;
    bit         m_q[$];
    logic [3:0] m_busy, m_dbl, m_start;
    logic       m_acc, m_rej, m_err;

    always #5 clk = ~clk;

    laundry_dispatch_controller #(
        .N_MACHINES   (N),
        .PRICE_SINGLE (PS),
        .PRICE_DOUBLE (PD),
        .QDEPTH       (QD),
        .CREDIT_W     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin         (coin),
        .req_start    (req_start),
        .req_double   (req_double),
        .mach_en      (mach_en),
        .wash_done    (wash_done),
        .start        (start),
        .dbl          (dbl),
        .busy         (busy),
        .credit       (credit),
        .q_count      (q_count),
        .req_accept   (req_accept),
        .req_reject   (req_reject),
        .err_spurious (err_spurious)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        m_rr     = 0;
        m_q.delete();
        m_busy   = '0;
        m_dbl    = '0;
        m_start  = '0;
        m_acc    = 1'b0;
        m_rej    = 1'b0;
        m_err    = 1'b0;
    endtask

    // One clock of customer/machine behaviour, from the inputs seen at the edge.
    task automatic model_step();
        int   price;
        int   grant;
        int   cnt;
        logic acc;
        price = req_double ? PD : PS;
        cnt   = m_q.size();
        acc   = req_start && (m_credit >= price) && (cnt < QD);
        m_acc = acc;
        m_rej = req_start && !acc;
        grant = -1;
        if (cnt > 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_rr + k) % N;
                if (grant < 0 && mach_en[idx] && !m_busy[idx]) grant = idx;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (wash_done[i]) begin
                if (m_busy[i]) m_busy[i] = 1'b0;
                else m_err = 1'b1;
            end
        end
        m_start = '0;
        if (grant >= 0) begin
            m_dbl[grant]   = m_q.pop_front();
            m_busy[grant]  = 1'b1;
            m_start[grant] = 1'b1;
            m_rr           = (grant + 1) % N;
        end
        if (acc) m_q.push_back(req_double);
        m_credit = m_credit + int'(coin) - (acc ? price : 0);
        if (m_credit > CMAX) m_credit = CMAX;
    endtask

    task automatic check_all();
        check_eq("start", start, m_start);
        check_eq("dbl", dbl, m_dbl);
        check_eq("busy", busy, m_busy);
        check_eq("credit", credit, m_credit);
        check_eq("q_count", q_count, m_q.size());
        check_eq("req_accept", req_accept, m_acc);
        check_eq("req_reject", req_reject, m_rej);
        check_eq("err_spurious", err_spurious, m_err);
    endtask

    task automatic tick(input logic c, input logic rs, input logic rd,
                        input logic [3:0] en, input logic [3:0] wd);
        coin       = c;
        req_start  = rs;
        req_double = rd;
        mach_en    = en;
        wash_done  = wd;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        check_eq("reset_credit", credit, 32'd0);
        check_eq("reset_busy", busy, 32'd0);

        // Basic dispatch
        tick(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        tick(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        tick(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        check_eq("basic_accept", req_accept, 32'd1);
        check_eq("basic_credit", credit, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        check_eq("basic_start", start, 32'h1);
        check_eq("basic_dbl", dbl[0], 32'd0);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h1);
        check_eq("basic_release", busy[0], 32'd0);

        // Coin arriving with a double request does not count toward the check
        tick(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        tick(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        tick(1'b1, 1'b1, 1'b1, 4'hF, 4'h0);
        check_eq("race_reject", req_reject, 32'd1);
        check_eq("race_credit", credit, 32'd3);
        tick(1'b0, 1'b1, 1'b1, 4'hF, 4'h0);
        check_eq("race_accept", req_accept, 32'd1);
        check_eq("race_credit0", credit, 32'd0);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        check_eq("race_start", start, 32'h2);
        check_eq("race_dbl", dbl[1], 32'd1);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h2);

        // Round-robin skipping a disabled machine
        do_reset();
        repeat (15) tick(1'b1, 1'b0, 1'b0, 4'b1011, 4'h0);
        check_eq("rr_credit15", credit, 32'd15);
        repeat (4) tick(1'b0, 1'b1, 1'b0, 4'b1011, 4'h0);
        check_eq("rr_third_start", start, 32'h8);
        tick(1'b0, 1'b0, 1'b0, 4'b1011, 4'h0);
        check_eq("rr_busy", busy, 32'hB);
        check_eq("rr_qcount", q_count, 32'd1);
        check_eq("rr_credit", credit, 32'd7);
        tick(1'b0, 1'b0, 1'b0, 4'b1011, 4'h2);
        tick(1'b0, 1'b0, 1'b0, 4'b1011, 4'h0);
        check_eq("rr_redispatch", start, 32'h2);

        // FIFO full
        do_reset();
        repeat (15) tick(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        repeat (4) tick(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        check_eq("full_allbusy", busy, 32'hF);
        repeat (8) tick(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        repeat (5) tick(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        check_eq("full_reject", req_reject, 32'd1);
        check_eq("full_credit", credit, 32'd7);
        check_eq("full_qcount", q_count, 32'd4);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h4);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        check_eq("full_one_start", start, 32'h4);
        check_eq("full_qcount3", q_count, 32'd3);

        // Saturation, spurious done, asynchronous reset mid-wash
        do_reset();
        repeat (20) tick(1'b1, 1'b0, 1'b0, 4'hF, 4'h0);
        check_eq("sat_credit", credit, 32'd15);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h4);
        check_eq("spurious_set", err_spurious, 32'd1);
        repeat (3) tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        check_eq("spurious_held", err_spurious, 32'd1);
        tick(1'b0, 1'b1, 1'b1, 4'hF, 4'h0);
        tick(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
        check_eq("pre_rst_busy", busy[0], 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_busy", busy, 32'd0);
        check_eq("arst_start", start, 32'd0);
        check_eq("arst_dbl", dbl, 32'd0);
        check_eq("arst_credit", credit, 32'd0);
        check_eq("arst_qcount", q_count, 32'd0);
        check_eq("arst_accept", req_accept, 32'd0);
        check_eq("arst_err", err_spurious, 32'd0);
        model_reset();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] en;
            logic [3:0] wd;
            logic       c;
            logic       rs;
            logic       rd;
            if (cyc % 64 == 0) en = 4'($urandom_range(0, 15));
            else en = mach_en;
            if (cyc % 64 == 1) en = 4'hF;
            c  = ((cyc / 200) % 2 == 1) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) == 1);
            rs = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 1) == 1);
            for (int i = 0; i < N; i++) begin
                wd[i] = m_busy[i] && ($urandom_range(0, 4) == 0);
            end
            tick(c, rs, rd, en, wd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/laundry_dispatch_controller.md
# laundry_dispatch_controller

Front-end controller for a bank of washing machines sharing one coin slot and one start panel. Accumulates coin credit, prices each customer request as single or double wash, holds paid jobs in a small FIFO, and dispatches each job to a free, enabled machine in round-robin order. It drives each machine's `coin_in` and `double_wash` inputs and releases the machine on its `wash_done` pulse.

## Interface
- `N_MACHINES`, 4: number of machines served (2..8).
- `PRICE_SINGLE`, 2: coin units charged for a single wash.
- `PRICE_DOUBLE`, 3: coin units charged for a double wash.
- `QDEPTH`, 4: pending-job FIFO depth (power of 2).
- `CREDIT_W`, 4: credit counter width.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `coin` input 1: one-cycle pulse, one coin unit inserted.
- `req_start` input 1: one-cycle pulse, customer presses start.
- `req_double` input 1: qualifies `req_start`; 1 means double wash.
- `mach_en` input N_MACHINES: per-machine enable; 0 means out of service.
- `wash_done` input N_MACHINES: one-cycle done pulses from the machines.
- `start` output N_MACHINES: one-cycle pulse to the machine's `coin_in`.
- `dbl` output N_MACHINES: level driven to the machine's `double_wash`; held while that machine is busy.
- `busy` output N_MACHINES: per-machine BUSY state.
- `credit` output CREDIT_W: current credit.
- `q_count` output $clog2(QDEPTH)+1: jobs pending.
- `req_accept` output 1: one-cycle pulse when a request is accepted.
- `req_reject` output 1: one-cycle pulse when a request is rejected.
- `err_spurious` output 1: sticky flag; set by `wash_done` from a FREE machine.

## Operation
- **Credit** (cycle t inputs, registered update at t+1):
  - credit_next = credit + coin − (accept ? price : 0), saturating at 2^CREDIT_W−1.
  - The price check uses the registered credit, so a coin arriving in the same cycle does not count toward the check.
- **Request** (`req_start` high):
  - Accept if credit ≥ price(`req_double`) and q_count < QDEPTH (registered values). Accept enqueues `req_double` and pulses `req_accept`.
  - Otherwise pulse `req_reject`; credit and queue are unchanged.
  - Full is judged on the registered count, so a dequeue in the same cycle does not free a slot for that request.
- **Per-machine FSM**:
  - FREE→BUSY on dispatch.
  - BUSY→FREE on a `wash_done` bit.
  - `wash_done` in FREE: ignored, sets `err_spurious`.
  - `mach_en` falling while BUSY does not abort the wash; the machine is excluded only from future dispatch.
- **Dispatch**:
  - At most one dispatch per cycle.
  - Eligible when q_count > 0 and at least one machine is FREE with `mach_en` = 1 (registered state).
  - Grant goes to the first eligible index at or after `rr_ptr`, wrapping modulo N_MACHINES.
  - On grant: pulse `start[i]`, set `dbl[i]` to the FIFO head, set `busy[i]`, dequeue, and set `rr_ptr` = i+1 mod N.
- **Simultaneous events**:
  - Enqueue and dequeue in the same cycle: q_count is unchanged.
  - A machine whose `wash_done` arrives at t is not eligible before t+1.
- **Reset**: all state clears, including the FIFO contents and `err_spurious`.

## Timing
- **Reset values**: `start`, `dbl`, `busy` = 0; `credit` = 0; `q_count` = 0; `req_accept`, `req_reject`, `err_spurious` = 0; `rr_ptr` = 0.
- **Register boundary**: all outputs are registered; no combinational input-to-output path.
- **Request latency**: `req_start` at t gives `req_accept`/`req_reject`, updated credit and q_count at t+1. Earliest `start` is t+2.
- **Release latency**: `wash_done[i]` at t gives `busy[i]` = 0 at t+1. Earliest re-dispatch `start[i]` is t+2.
- **`dbl[i]` hold**: changes only at dispatch; stays valid from the `start[i]` cycle through the `wash_done[i]` cycle.
- **Reset mid-operation**: outputs drop at once (asynchronously). In-flight jobs and credit are lost; a pending `start` pulse is suppressed.

## Structure
- **Package `laundry_pkg`**:
  - Default prices.
  - Machine state enum {M_FREE, M_BUSY}.
  - `price_f(double)` function.
- **Sub-module `job_fifo`**:
  - Parameterised DEPTH/WIDTH=1.
  - Synchronous push/pop.
  - Registered count; exposes head, empty, full.
- **Top level**: credit logic, round-robin grant and the per-machine FSM array stay in the top module.

## Test plan
- **Basic dispatch**: 2 coins, then `req_start` (single) → `req_accept` at t+1, credit 0, `start[0]` at t+2, `dbl[0]` = 0. `wash_done[0]` → `busy[0]` = 0 one cycle later.
- **Insufficient credit / coin race**: credit 2, `req_double` with a coin in the same cycle → `req_reject`, credit becomes 3. Next `req_double` is accepted, credit 0, `dbl[i]` = 1.
- **Round-robin and disable**: credit 15, `mach_en` = 4'b1011, 4 single requests → starts on machines 0, 1, 3, then queued. After `wash_done[1]`, the 4th job goes to machine 1.
- **FIFO full**: all machines busy, credit 15, 5 single requests → 4 accepted, 5th rejected, credit 7, q_count 4. One `wash_done` → exactly one dispatch, q_count 3.
- **Saturation, spurious done, reset**:
  - 20 coins → credit 15.
  - `wash_done[2]` while machine 2 is FREE → `err_spurious` = 1, held until reset.
  - `rst_n` low during a BUSY wash → all outputs 0 immediately.
